// File: rtl/radio_controller_txgainspi_pkg.sv
// Shared definitions for the Tx-gain SPI writer: FSM states, word layout and register address.
package radio_controller_txgainspi_pkg;

    localparam int         WORD_W      = 18;
    localparam logic [4:0] LAST_BIT    = 5'(WORD_W - 1);
    localparam logic [3:0] TXGAIN_ADDR = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spiState_t;

    // 8 zero pad bits, 6 gain bits, then the 4-bit register address.
    function automatic logic [WORD_W-1:0] gainWord(input logic [5:0] gain);
        return {8'b0, gain, TXGAIN_ADDR};
    endfunction

endpackage

// File: rtl/radio_controller_txgainspi_spishift.sv
// 18-bit load/shift register plus the SCLK half-period timer, both frozen at load time.
module radio_controller_SPIShift
    import radio_controller_txgainspi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] loadWord,
    input  logic [3:0]        loadDiv,
    input  logic              run,
    input  logic              shift,
    output logic              halfDone,
    output logic              nextBit
);

    logic [WORD_W-1:0] shiftReg;
    logic [3:0]        halfLen;
    logic [3:0]        halfCnt;

    assign halfDone = run && (halfCnt == halfLen);
    assign nextBit  = shiftReg[WORD_W-2];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftReg <= '0;
            halfLen  <= '0;
            halfCnt  <= '0;
        end else if (load) begin
            shiftReg <= loadWord;
            halfLen  <= loadDiv;
            halfCnt  <= '0;
        end else begin
            if (shift)
                shiftReg <= {shiftReg[WORD_W-2:0], 1'b0};
            if (halfDone)
                halfCnt <= '0;
            else if (run)
                halfCnt <= halfCnt + 4'd1;
        end
    end

endmodule

// File: rtl/radio_controller_txgainspi.sv
// Serialises Tx-gain changes onto a 3-wire SPI bus; optional software word path under RADIO_TXGAIN_SWSPI_EN.
module radio_controller_txgainspi
    import radio_controller_txgainspi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_enable,
    input  logic [5:0]        hw_TxGain,
    input  logic [3:0]        spi_clkDiv,
`ifdef RADIO_TXGAIN_SWSPI_EN
    input  logic              sw_req,
    input  logic [WORD_W-1:0] sw_word,
    output logic              sw_ack,
`endif
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_csb,
    output logic              busy,
    output logic [7:0]        update_count
);

    spiState_t         state;
    logic [5:0]        lastSent;
    logic [4:0]        bitCnt;
    logic              isSw;
    logic              startSw;
    logic              startGain;
    logic              load;
    logic [WORD_W-1:0] loadWord;
    logic              halfDone;
    logic              nextBit;

`ifdef RADIO_TXGAIN_SWSPI_EN
    assign startSw  = (state == ST_IDLE) && spi_enable && sw_req;
    assign loadWord = startSw ? sw_word : gainWord(hw_TxGain);
`else
    assign startSw  = 1'b0;
    assign loadWord = gainWord(hw_TxGain);
`endif
    assign startGain = (state == ST_IDLE) && spi_enable && (hw_TxGain != lastSent) && !startSw;
    assign load      = startGain || startSw;

    radio_controller_SPIShift u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .loadWord (loadWord),
        .loadDiv  (spi_clkDiv),
        .run      (state != ST_IDLE),
        .shift    ((state == ST_SHIFT) && spi_sclk && halfDone),
        .halfDone (halfDone),
        .nextBit  (nextBit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            spi_csb      <= 1'b1;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            busy         <= 1'b0;
            update_count <= '0;
            lastSent     <= '0;
            bitCnt       <= '0;
            isSw         <= 1'b0;
`ifdef RADIO_TXGAIN_SWSPI_EN
            sw_ack       <= 1'b0;
`endif
        end else begin
`ifdef RADIO_TXGAIN_SWSPI_EN
            sw_ack <= startSw;
`endif
            case (state)
                ST_IDLE: if (load) begin
                    state    <= ST_SETUP;
                    spi_csb  <= 1'b0;
                    spi_sclk <= 1'b0;
                    spi_mosi <= loadWord[WORD_W-1];
                    busy     <= 1'b1;
                    bitCnt   <= '0;
                    isSw     <= startSw;
                    if (startGain)
                        lastSent <= hw_TxGain;
                end
                ST_SETUP: if (halfDone) begin
                    state    <= ST_SHIFT;
                    spi_sclk <= 1'b1;
                end
                ST_SHIFT: if (halfDone) begin
                    // Data moves on the falling edge so the slave samples a stable bit on the rising edge.
                    if (spi_sclk) begin
                        spi_sclk <= 1'b0;
                        spi_mosi <= nextBit;
                    end else if (bitCnt == LAST_BIT) begin
                        state    <= ST_HOLD;
                        spi_mosi <= 1'b0;
                    end else begin
                        spi_sclk <= 1'b1;
                        bitCnt   <= bitCnt + 5'd1;
                    end
                end
                ST_HOLD: if (halfDone) begin
                    state   <= ST_GAP;
                    spi_csb <= 1'b1;
                end
                ST_GAP: if (halfDone) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!isSw)
                        update_count <= update_count + 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
